ps2_key_ctrl: RTL and testbench
===============================

// Module: ps2_key_ctrl
// PURPOSE
//  Sequences the raw byte stream from the PS/2 receiver into key events.
//  Strips E0/F0/E1 prefixes, suppresses typematic repeats and tracks the held key.
//  Queues {ext,brk,code} events in a FIFO for downstream consumers (display, ASCII map).
//  Sits between the PS/2 receiver and the application logic.
// PARAMETERS
//  FIFO_DEPTH  8  event FIFO entries; power of 2, >=2
//  REPEAT_EN   0  1: typematic repeat makes are queued as events; 0: they are dropped
//  PAUSE_LEN   7  bytes discarded after an E1 prefix (Pause key sequence)
// PORTS
//  clk         in   1   clock
//  resetn      in   1   synchronous, active-low reset
//  byte_valid  in   1   receiver strobe; may stay high many cycles; a byte is accepted on its 0->1 edge only
//  byte_data   in   8   scan-code byte, stable while byte_valid=1
//  evt_valid   out  1   FIFO non-empty
//  evt_ready   in   1   consumer pops head when evt_valid&evt_ready
//  evt_code    out  8   head event scan code
//  evt_ext     out  1   head event had E0 prefix
//  evt_brk     out  1   head event is a release
//  held        out  1   a key is currently pressed
//  held_code   out  9   {ext,code} of the last pressed key
//  press_cnt   out  8   count of new key presses, wraps 255->0
//  ovf         out  1   sticky: an event was dropped because the FIFO was full
//  err         out  1   sticky: protocol error or keyboard error byte seen
//  clr         in   1   clears press_cnt, ovf and err next edge; FIFO, FSM and held are untouched
// BEHAVIOUR
//  - Reset: FSM=IDLE, FIFO empty, evt_valid=0, held=0, held_code=0, press_cnt=0, ovf=0, err=0, edge-detect reg=0.
//  - Accept: acc = byte_valid & ~bv_q (bv_q is a registered copy). All decode happens on the acc edge.
//  - FSM states and transitions on acc:
//      IDLE:    E0->EXT; F0->BRK; E1->PAUSE (skip_cnt=PAUSE_LEN); other bytes -> make(ext=0)
//      EXT:     F0->EXT_BRK; other bytes -> make(ext=1), then IDLE
//      BRK:     other bytes -> brk(ext=0), then IDLE
//      EXT_BRK: other bytes -> brk(ext=1), then IDLE
//      PAUSE:   discard the byte; skip_cnt--; at 1 -> IDLE; no events
//  - Error bytes 00/FF in any state except PAUSE: discard, set err, go to IDLE.
//  - Error prefixes (E0/E1 in BRK/EXT_BRK, E0/E1 in EXT, F0 in BRK/EXT_BRK): set err, go to IDLE.
//    The offending byte is not reinterpreted.
//  - make, when held & held_code=={ext,code} (repeat): push only if REPEAT_EN; press_cnt unchanged.
//  - make, otherwise: push event, held<=1, held_code<={ext,code}, press_cnt+=1.
//  - brk: always push event; if held_code=={ext,code} then held<=0.
//  - Latency: the event is written at the acc edge; evt_valid/evt_* are valid from the next cycle.
//    FIFO output is first-word-fall-through.
//  - FIFO full:
//      push with no pop: event dropped, ovf<=1
//      push with a pop in the same cycle: both occur, count unchanged
//      empty FIFO with evt_ready=1: no effect
//  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
//  - clr coinciding with a press: press_cnt<=0 and ovf/err<=0 (clr wins); the press event is still queued.
//  - Reset during a prefix sequence discards the partial sequence.
//  - byte_valid high out of reset is accepted once, because bv_q resets to 0.
// STRUCTURE
//  - ps2_pkg:
//      localparams PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_ERR0=8'h00, PS2_ERR1=8'hFF
//      FSM state encoding (IDLE, EXT, BRK, EXT_BRK, PAUSE)
//      EVT_W=10; event word layout {ext,brk,code[7:0]}
//  - Sub-module ps2_evt_fifo: sync FIFO with parameters WIDTH, DEPTH.
//    Ports push/pop/din/dout/full/empty; FWFT output.
//  - Top level: edge detect, FSM, skip counter, held tracker, press counter, sticky flags.
// TESTING
//  - Bytes 1C, F0, 1C (acc edges ~100 cycles apart) -> events {0,0,1C} then {0,1,1C};
//    press_cnt=1; held=1 after the make, 0 after the break.
//  - byte_valid held high 50 cycles with byte 1C -> exactly one event; press_cnt=1.
//  - Bytes E0, 75, E0, F0, 75 -> events {1,0,75}, {1,1,75}; held_code=9'h175.
//  - Bytes 1C x4 (repeats), REPEAT_EN=0 -> 1 event, press_cnt=1.
//    Same stimulus with REPEAT_EN=1 -> 4 events, press_cnt=1.
//  - evt_ready=0, FIFO_DEPTH+2 distinct makes -> FIFO_DEPTH entries held, ovf=1.
//    Then evt_ready=1 -> entries drain in order; clr -> ovf=0, press_cnt=0.
//  - Bytes E1,14,77,E1,F0,14,F0,77 then 1C -> only {0,0,1C} queued.
//    Bytes F0, E0 -> err=1, FSM=IDLE; next byte 1C yields a make.
//  - Assert resetn=0 after E0 -> all outputs return to reset values;
//    next byte 75 yields {0,0,75}.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ps2_pkg                                                 |
// | Brief    : PS/2 scan-code constants, decoder states, event layout  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package ps2_pkg;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] PS2_PAUSE = 8'hE1;
   localparam logic [7:0] PS2_ERR0  = 8'h00;
   localparam logic [7:0] PS2_ERR1  = 8'hFF;

   localparam int EVT_W = 10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_EXT     = 3'd1,
      ST_BRK     = 3'd2,
      ST_EXT_BRK = 3'd3,
      ST_PAUSE   = 3'd4
   } ps2_state_t;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_evt_t;

   function automatic logic is_err_byte(input logic [7:0] b);
      return (b == PS2_ERR0) || (b == PS2_ERR1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_evt_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ps2_evt_fifo                                            |
// | Brief    : Synchronous first-word-fall-through event FIFO          |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module ps2_evt_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int          AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign empty = (r_count == '0);
   assign full  = (r_count == C_FULL);
   assign dout  = r_mem[r_rptr];

   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= din;
   end

endmodule
`default_nettype wire

// File: rtl/ps2_key_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ps2_key_ctrl                                            |
// | Brief    : PS/2 byte stream to key-event sequencer with event FIFO |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module ps2_key_ctrl
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int REPEAT_EN  = 0,
   parameter int PAUSE_LEN  = 7
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [7:0] evt_code,
   output logic       evt_ext,
   output logic       evt_brk,
   output logic       held,
   output logic [8:0] held_code,
   output logic [7:0] press_cnt,
   output logic       ovf,
   output logic       err,
   input  logic       clr
);

   localparam int             SKW    = (PAUSE_LEN > 1) ? $clog2(PAUSE_LEN + 1) : 1;
   localparam logic [SKW-1:0] C_SKIP = SKW'(PAUSE_LEN);
   localparam logic           C_REP  = (REPEAT_EN != 0);

   ps2_state_t       r_state, w_state_nxt;
   logic [SKW-1:0]   r_skip_cnt, w_skip_nxt;
   logic             r_bv_q;
   logic             r_held;
   logic [8:0]       r_held_code;
   logic [7:0]       r_press_cnt;
   logic             r_ovf;
   logic             r_err;

   logic             w_acc;
   logic             w_evt_go;
   logic             w_evt_ext;
   logic             w_evt_brk;
   logic             w_proto_err;
   logic [8:0]       w_key;
   logic             w_repeat;
   logic             w_push;
   logic             w_new_press;
   logic             w_pop;
   logic             w_drop;
   logic             w_full;
   logic             w_empty;
   ps2_evt_t         w_din;
   logic [EVT_W-1:0] w_dout;
   ps2_evt_t         w_head;

   assign w_acc = byte_valid & ~r_bv_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state    <= ST_IDLE;
         r_skip_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_skip_cnt <= w_skip_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_skip_nxt  = r_skip_cnt;
      w_evt_go    = 1'b0;
      w_evt_ext   = 1'b0;
      w_evt_brk   = 1'b0;
      w_proto_err = 1'b0;
      if (w_acc) begin
         if (r_state == ST_PAUSE) begin
            // Pause bytes are swallowed whole, error codes included.
            if (r_skip_cnt <= SKW'(1)) begin
               w_state_nxt = ST_IDLE;
               w_skip_nxt  = '0;
            end else begin
               w_skip_nxt = r_skip_cnt - 1'b1;
            end
         end else if (is_err_byte(byte_data)) begin
            w_proto_err = 1'b1;
            w_state_nxt = ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (byte_data == PS2_EXT) begin
                     w_state_nxt = ST_EXT;
                  end else if (byte_data == PS2_BRK) begin
                     w_state_nxt = ST_BRK;
                  end else if (byte_data == PS2_PAUSE) begin
                     w_state_nxt = ST_PAUSE;
                     w_skip_nxt  = C_SKIP;
                  end else begin
                     w_evt_go = 1'b1;
                  end
               end
               ST_EXT: begin
                  if (byte_data == PS2_BRK) begin
                     w_state_nxt = ST_EXT_BRK;
                  end else if (byte_data == PS2_EXT || byte_data == PS2_PAUSE) begin
                     w_proto_err = 1'b1;
                     w_state_nxt = ST_IDLE;
                  end else begin
                     w_evt_go    = 1'b1;
                     w_evt_ext   = 1'b1;
                     w_state_nxt = ST_IDLE;
                  end
               end
               ST_BRK, ST_EXT_BRK: begin
                  w_state_nxt = ST_IDLE;
                  if (byte_data == PS2_EXT || byte_data == PS2_PAUSE || byte_data == PS2_BRK) begin
                     w_proto_err = 1'b1;
                  end else begin
                     w_evt_go  = 1'b1;
                     w_evt_brk = 1'b1;
                     w_evt_ext = (r_state == ST_EXT_BRK);
                  end
               end
               default: w_state_nxt = ST_IDLE;
            endcase
         end
      end
   end

   assign w_key       = {w_evt_ext, byte_data};
   assign w_repeat    = r_held && (r_held_code == w_key);
   assign w_push      = w_evt_go && (w_evt_brk || !w_repeat || C_REP);
   assign w_new_press = w_evt_go && !w_evt_brk && !w_repeat;
   assign w_pop       = evt_valid & evt_ready;
   assign w_drop      = w_push & w_full & ~w_pop;
   assign w_din       = '{ext: w_evt_ext, brk: w_evt_brk, code: byte_data};

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_bv_q      <= 1'b0;
         r_held      <= 1'b0;
         r_held_code <= '0;
         r_press_cnt <= '0;
         r_ovf       <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_bv_q <= byte_valid;
         if (w_new_press) begin
            r_held      <= 1'b1;
            r_held_code <= w_key;
         end else if (w_evt_go && w_evt_brk && (r_held_code == w_key)) begin
            r_held <= 1'b0;
         end
         // clr outranks any same-cycle increment or sticky set.
         if (clr) begin
            r_press_cnt <= '0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
         end else begin
            if (w_new_press) r_press_cnt <= r_press_cnt + 1'b1;
            if (w_drop)      r_ovf       <= 1'b1;
            if (w_proto_err) r_err       <= 1'b1;
         end
      end
   end

   ps2_evt_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (w_push),
      .pop    (w_pop),
      .din    (w_din),
      .dout   (w_dout),
      .full   (w_full),
      .empty  (w_empty)
   );

   assign w_head    = w_dout;
   assign evt_valid = ~w_empty;
   assign evt_code  = w_head.code;
   assign evt_ext   = w_head.ext;
   assign evt_brk   = w_head.brk;
   assign held      = r_held;
   assign held_code = r_held_code;
   assign press_cnt = r_press_cnt;
   assign ovf       = r_ovf;
   assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_ps2_key_ctrl                                         |
// | Brief    : Two DUTs (repeat off/on) against a prefix-flag model    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_ps2_key_ctrl;

   localparam int DEPTH = 8;
   localparam int PLEN  = 7;

   logic       clk;
   logic       resetn;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       evt_ready;
   logic       clr;

   logic [1:0]       evt_valid_v, evt_ext_v, evt_brk_v, held_v, ovf_v, err_v;
   logic [1:0][7:0]  evt_code_v, press_cnt_v;
   logic [1:0][8:0]  held_code_v;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      ps2_key_ctrl #(
         .FIFO_DEPTH (DEPTH),
         .REPEAT_EN  (g),
         .PAUSE_LEN  (PLEN)
      ) u_dut (
         .clk        (clk),
         .resetn     (resetn),
         .byte_valid (byte_valid),
         .byte_data  (byte_data),
         .evt_valid  (evt_valid_v[g]),
         .evt_ready  (evt_ready),
         .evt_code   (evt_code_v[g]),
         .evt_ext    (evt_ext_v[g]),
         .evt_brk    (evt_brk_v[g]),
         .held       (held_v[g]),
         .held_code  (held_code_v[g]),
         .press_cnt  (press_cnt_v[g]),
         .ovf        (ovf_v[g]),
         .err        (err_v[g]),
         .clr        (clr)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Model: pending prefix flags plus a skip count, events in plain queues.
   bit         m_bvq;
   int         m_skip [2];
   bit         m_ext  [2];
   bit         m_brk  [2];
   bit         m_held [2];
   logic [8:0] m_hcode[2];
   logic [7:0] m_cnt  [2];
   bit         m_ovf  [2];
   bit         m_err  [2];
   logic [9:0] mq0[$];
   logic [9:0] mq1[$];

   function automatic int qsize(input int i);
      return (i == 0) ? mq0.size() : mq1.size();
   endfunction

   function automatic logic [9:0] qfront(input int i);
      return (i == 0) ? mq0[0] : mq1[0];
   endfunction

   task automatic qpop(input int i);
      if (i == 0) void'(mq0.pop_front());
      else        void'(mq1.pop_front());
   endtask

   task automatic qpush(input int i, input logic [9:0] v);
      if (qsize(i) < DEPTH) begin
         if (i == 0) mq0.push_back(v);
         else        mq1.push_back(v);
      end else begin
         m_ovf[i] = 1'b1;
      end
   endtask

   task automatic model_byte(input int i, input logic [7:0] b);
      logic [8:0] key;
      if (m_skip[i] > 0) begin
         m_skip[i]--;
         return;
      end
      if (b == 8'h00 || b == 8'hFF) begin
         m_err[i] = 1'b1; m_ext[i] = 1'b0; m_brk[i] = 1'b0;
         return;
      end
      if (b == 8'hE0 || b == 8'hE1) begin
         if (m_ext[i] || m_brk[i]) begin
            m_err[i] = 1'b1; m_ext[i] = 1'b0; m_brk[i] = 1'b0;
         end else if (b == 8'hE0) begin
            m_ext[i] = 1'b1;
         end else begin
            m_skip[i] = PLEN;
         end
         return;
      end
      if (b == 8'hF0) begin
         if (m_brk[i]) begin
            m_err[i] = 1'b1; m_ext[i] = 1'b0; m_brk[i] = 1'b0;
         end else begin
            m_brk[i] = 1'b1;
         end
         return;
      end
      key = {m_ext[i], b};
      if (m_brk[i]) begin
         qpush(i, {m_ext[i], 1'b1, b});
         if (m_hcode[i] == key) m_held[i] = 1'b0;
      end else if (m_held[i] && m_hcode[i] == key) begin
         if (i == 1) qpush(i, {m_ext[i], 1'b0, b});
      end else begin
         qpush(i, {m_ext[i], 1'b0, b});
         m_held[i]  = 1'b1;
         m_hcode[i] = key;
         m_cnt[i]   = m_cnt[i] + 8'd1;
      end
      m_ext[i] = 1'b0;
      m_brk[i] = 1'b0;
   endtask

   task automatic model_edge();
      bit acc;
      if (!resetn) begin
         m_bvq = 1'b0;
         for (int i = 0; i < 2; i++) begin
            m_skip[i] = 0; m_ext[i] = 1'b0; m_brk[i] = 1'b0; m_held[i] = 1'b0;
            m_hcode[i] = '0; m_cnt[i] = '0; m_ovf[i] = 1'b0; m_err[i] = 1'b0;
         end
         mq0.delete();
         mq1.delete();
         return;
      end
      acc   = byte_valid && !m_bvq;
      m_bvq = byte_valid;
      for (int i = 0; i < 2; i++) begin
         bit popped;
         popped = (qsize(i) > 0) && evt_ready;
         if (popped) qpop(i);
         if (acc) model_byte(i, byte_data);
         if (clr) begin
            m_cnt[i] = '0; m_ovf[i] = 1'b0; m_err[i] = 1'b0;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_edge();
   end

   function automatic logic [9:0] head(input int i);
      return {evt_ext_v[i], evt_brk_v[i], evt_code_v[i]};
   endfunction

   function automatic logic [31:0] act_vec(input int i);
      return {1'b0, evt_valid_v[i], evt_valid_v[i] ? head(i) : 10'd0, held_v[i],
              held_code_v[i], press_cnt_v[i], ovf_v[i], err_v[i]};
   endfunction

   function automatic logic [31:0] exp_vec(input int i);
      logic [9:0] h;
      h = (qsize(i) > 0) ? qfront(i) : 10'd0;
      return {1'b0, qsize(i) > 0, h, m_held[i], m_hcode[i], m_cnt[i], m_ovf[i], m_err[i]};
   endfunction

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         cmp("cycle_rep0", act_vec(0), exp_vec(0));
         cmp("cycle_rep1", act_vec(1), exp_vec(1));
      end
   end

   task automatic send(input logic [7:0] b, input int hi, input int gap);
      byte_data  = b;
      byte_valid = 1'b1;
      repeat (hi) @(negedge clk);
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic pop1();
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
   endtask

   task automatic drain();
      evt_ready = 1'b1;
      repeat (DEPTH + 4) @(negedge clk);
      evt_ready = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
   endtask

   logic [7:0] pool [6] = '{8'h1C, 8'h1D, 8'h75, 8'h12, 8'h5A, 8'h6B};
   logic [7:0] pseq [9] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};

   initial begin
      resetn = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; evt_ready = 1'b0; clr = 1'b0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      resetn = 1'b1;
      @(negedge clk);
      cmp("rst_valid", {31'd0, evt_valid_v[0]}, 32'd0);
      cmp("rst_held", {31'd0, held_v[0]}, 32'd0);
      cmp("rst_cnt", {24'd0, press_cnt_v[0]}, 32'd0);

      // make / break of 1C
      send(8'h1C, 2, 100);
      cmp("s1_held_make", {31'd0, held_v[0]}, 32'd1);
      send(8'hF0, 2, 100);
      send(8'h1C, 2, 100);
      cmp("s1_held_brk", {31'd0, held_v[0]}, 32'd0);
      cmp("s1_cnt", {24'd0, press_cnt_v[0]}, 32'd1);
      cmp("s1_model_n", qsize(0), 32'd2);
      cmp("s1_ev0", {22'd0, head(0)}, 32'h01C);
      pop1();
      cmp("s1_ev1", {22'd0, head(0)}, 32'h11C);
      drain();

      // long strobe accepted once
      do_clr();
      send(8'h1C, 50, 3);
      cmp("s2_cnt", {24'd0, press_cnt_v[0]}, 32'd1);
      cmp("s2_ev", {22'd0, head(0)}, 32'h01C);
      pop1();
      cmp("s2_one_evt", {31'd0, evt_valid_v[0]}, 32'd0);
      send(8'hF0, 1, 2); send(8'h1C, 1, 2);
      drain();

      // extended make / break
      do_clr();
      send(8'hE0, 1, 2); send(8'h75, 1, 2);
      send(8'hE0, 1, 2); send(8'hF0, 1, 2); send(8'h75, 1, 2);
      cmp("s3_hcode", {23'd0, held_code_v[0]}, 32'h175);
      cmp("s3_ev0", {22'd0, head(0)}, 32'h275);
      pop1();
      cmp("s3_ev1", {22'd0, head(0)}, 32'h375);
      drain();

      // typematic repeats
      do_clr();
      repeat (4) send(8'h1C, 1, 2);
      cmp("s4_model_n0", qsize(0), 32'd1);
      cmp("s4_model_n1", qsize(1), 32'd4);
      cmp("s4_cnt0", {24'd0, press_cnt_v[0]}, 32'd1);
      cmp("s4_cnt1", {24'd0, press_cnt_v[1]}, 32'd1);
      send(8'hF0, 1, 2); send(8'h1C, 1, 2);
      drain();

      // overflow then ordered drain
      do_clr();
      for (int k = 0; k < DEPTH + 2; k++) send(8'h10 + 8'(k), 1, 2);
      cmp("s5_ovf", {31'd0, ovf_v[0]}, 32'd1);
      cmp("s5_model_n", qsize(0), DEPTH);
      for (int k = 0; k < DEPTH; k++) begin
         cmp("s5_order", {22'd0, head(0)}, {24'd0, 8'h10 + 8'(k)});
         pop1();
      end
      cmp("s5_empty", {31'd0, evt_valid_v[0]}, 32'd0);
      do_clr();
      cmp("s5_clr_ovf", {31'd0, ovf_v[0]}, 32'd0);
      cmp("s5_clr_cnt", {24'd0, press_cnt_v[0]}, 32'd0);

      // pause sequence swallowed
      for (int k = 0; k < 9; k++) send(pseq[k], 1, 2);
      cmp("s6_model_n", qsize(0), 32'd1);
      cmp("s6_ev", {22'd0, head(0)}, 32'h01C);
      send(8'hF0, 1, 2); send(8'h1C, 1, 2);
      drain();

      // bad prefix
      send(8'hF0, 1, 2); send(8'hE0, 1, 2);
      cmp("s7_err", {31'd0, err_v[0]}, 32'd1);
      send(8'h1C, 1, 2);
      cmp("s7_ev", {22'd0, head(0)}, 32'h01C);
      drain();

      // reset mid-prefix, strobe already high at release
      send(8'hE0, 1, 2);
      resetn = 1'b0; byte_data = 8'h75; byte_valid = 1'b1;
      @(negedge clk);
      cmp("s8_rst_valid", {31'd0, evt_valid_v[0]}, 32'd0);
      cmp("s8_rst_held", {22'd0, held_v[0], held_code_v[0]}, 32'd0);
      cmp("s8_rst_flags", {22'd0, press_cnt_v[0], ovf_v[0], err_v[0]}, 32'd0);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      byte_valid = 1'b0;
      @(negedge clk);
      cmp("s8_ev", {22'd0, head(0)}, 32'h075);
      cmp("s8_model_n", qsize(0), 32'd1);
      drain();

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         int r;
         logic [7:0] b;
         r = int'($urandom_range(0, 99));
         if      (r < 8)  b = 8'hE0;
         else if (r < 16) b = 8'hF0;
         else if (r < 18) b = 8'hE1;
         else if (r < 20) b = 8'h00;
         else if (r < 21) b = 8'hFF;
         else             b = pool[$urandom_range(0, 5)];
         evt_ready = (n < 750) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 39) == 0) begin
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
         end
         if ($urandom_range(0, 399) == 0) begin
            resetn = 1'b0;
            @(negedge clk);
            resetn = 1'b1;
         end
         send(b, int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
      end
      drain();
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
